// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle CPU control FSM with opcode decode, memory-wait handshake,
// illegal-opcode detection, halt state and a retired-instruction counter.
`default_nettype none

module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  Opcode,
    input  logic        Beq_alu,
    input  logic        Mem_ready,
    output logic [3:0]  ALU_selection,
    output logic        ALUsrcB,
    output logic        PC_write,
    output logic        IR_write,
    output logic        Reg_write,
    output logic        Mem_read,
    output logic        Mem_write,
    output logic [1:0]  PC_source,
    output logic        IorD,
    output logic        RegDst,
    output logic        MemtoReg,
    output logic [3:0]  State,
    output logic        Illegal,
    output logic        Halted,
    output logic [31:0] Instr_count
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_WB     = 4'd3,
        S_ADDR   = 4'd4,
        S_MRD    = 4'd5,
        S_MWB    = 4'd6,
        S_MWR    = 4'd7,
        S_BR     = 4'd8,
        S_JMP    = 4'd9,
        S_HALT   = 4'd10
    } state_t;

    state_t state, next_state;
    logic   code_legal;
    logic   alu_op;
    logic   retire;

    always_comb begin
        case (Opcode[3:0])
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7, 4'h9, 4'hA: code_legal = 1'b1;
            default:                                              code_legal = 1'b0;
        endcase
    end

    // R-type (00cccc) and I-type (01cccc) share one path through EXEC/WB
    assign alu_op = ~Opcode[5] & code_legal;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_FETCH;
            Instr_count <= 32'd0;
        end else begin
            state <= next_state;
            if (retire)
                Instr_count <= Instr_count + 32'd1;
        end
    end

    always_comb begin
        next_state    = state;
        ALU_selection = 4'b0010;
        ALUsrcB       = 1'b0;
        PC_write      = 1'b0;
        IR_write      = 1'b0;
        Reg_write     = 1'b0;
        Mem_read      = 1'b0;
        Mem_write     = 1'b0;
        PC_source     = 2'b00;
        IorD          = 1'b0;
        RegDst        = 1'b0;
        MemtoReg      = 1'b0;
        Illegal       = 1'b0;
        Halted        = 1'b0;
        retire        = 1'b0;
        case (state)
            S_FETCH: begin
                Mem_read = 1'b1;
                if (Mem_ready) begin
                    IR_write   = 1'b1;
                    PC_write   = 1'b1;
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                if (alu_op)                next_state = S_EXEC;
                else if (Opcode == 6'h20)  next_state = S_ADDR;
                else if (Opcode == 6'h21)  next_state = S_ADDR;
                else if (Opcode == 6'h22)  next_state = S_BR;
                else if (Opcode == 6'h23)  next_state = S_JMP;
                else if (Opcode == 6'h3F)  next_state = S_HALT;
                else begin
                    Illegal    = 1'b1;
                    next_state = S_FETCH;
                end
            end
            S_EXEC: begin
                ALU_selection = Opcode[3:0];
                ALUsrcB       = Opcode[4];
                next_state    = S_WB;
            end
            S_WB: begin
                Reg_write  = 1'b1;
                RegDst     = ~Opcode[4];
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_ADDR: begin
                ALUsrcB    = 1'b1;
                next_state = Opcode[0] ? S_MWR : S_MRD;
            end
            S_MRD: begin
                Mem_read = 1'b1;
                IorD     = 1'b1;
                if (Mem_ready)
                    next_state = S_MWB;
            end
            S_MWB: begin
                Reg_write  = 1'b1;
                MemtoReg   = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_MWR: begin
                Mem_write = 1'b1;
                IorD      = 1'b1;
                if (Mem_ready) begin
                    retire     = 1'b1;
                    next_state = S_FETCH;
                end
            end
            S_BR: begin
                ALU_selection = 4'b0011;
                PC_source     = 2'b01;
                PC_write      = Beq_alu;
                retire        = 1'b1;
                next_state    = S_FETCH;
            end
            S_JMP: begin
                PC_source  = 2'b10;
                PC_write   = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_HALT: begin
                Halted = 1'b1;
            end
            default: next_state = S_FETCH;
        endcase
    end

    assign State = state;

endmodule

`default_nettype wire

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset SHALL be synchronous and active-high.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 Opcode  input  6  IR[31:26]; stable outside FETCH.
REQ-005 Beq_alu  input  1  ALU equality flag (ALU_in_A==ALU_in_B).
REQ-006 Mem_ready  input  1  memory access completes this cycle.
REQ-007 ALU_selection  output  4  ALU operation code.
REQ-008 ALUsrcB  output  1  0=register B, 1=sign-extended IR[15:0].
REQ-009 PC_write, IR_write, Reg_write, Mem_read, Mem_write  output  1 each  write/access strobes.
REQ-010 PC_source  output  2  00=PC+1, 01=branch target, 10=jump target.
REQ-011 IorD, RegDst, MemtoReg  output  1 each  address select (1=ALUout), destination select (1=rd), writeback select (1=memory data).
REQ-012 State  output  4  current state code; Illegal  output  1  one-cycle pulse; Halted  output  1; Instr_count  output  32  retired instructions.

Function
REQ-013 Opcode classes SHALL be: 00_cccc R-type, 01_cccc I-type, 100000 LW, 100001 SW, 100010 BEQ, 100011 JMP, 111111 HALT; cccc is the ALU code.
REQ-014 Legal cccc SHALL be 0000,0001,0010,0011,0100,0101,0111,1001,1010; every other cccc and every unlisted opcode SHALL be illegal.
REQ-015 States SHALL be FETCH=0, DECODE=1, EXEC=2, WB=3, ADDR=4, MRD=5, MWB=6, MWR=7, BR=8, JMP=9, HALT=10.
REQ-016 All strobes SHALL default to 0, ALU_selection to 0010, and the selects to 0 in every state unless stated below.
REQ-017 FETCH: Mem_read=1, IorD=0; hold while Mem_ready=0; when Mem_ready=1: IR_write=1, PC_write=1, PC_source=00, next DECODE.
REQ-018 DECODE: no strobes; next EXEC for legal R/I, ADDR for LW/SW, BR, JMP, HALT; illegal -> FETCH with Illegal=1 that cycle.
REQ-019 EXEC: ALU_selection=Opcode[3:0], ALUsrcB=Opcode[4]; next WB.
REQ-020 WB: Reg_write=1, MemtoReg=0, RegDst=~Opcode[4]; next FETCH.
REQ-021 ADDR: ALU_selection=0010, ALUsrcB=1; next MRD for LW, MWR for SW.
REQ-022 MRD: Mem_read=1, IorD=1; hold until Mem_ready=1; next MWB.
REQ-023 MWB: Reg_write=1, MemtoReg=1, RegDst=0; next FETCH.
REQ-024 MWR: Mem_write=1, IorD=1; hold until Mem_ready=1; next FETCH.
REQ-025 BR: ALU_selection=0011, ALUsrcB=0, PC_source=01, PC_write=Beq_alu; next FETCH.
REQ-026 JMP: PC_source=10, PC_write=1; next FETCH.
REQ-027 HALT: no strobes, Halted=1; state SHALL be held until rst.
REQ-028 Instr_count SHALL increment by 1, wrapping 0xFFFFFFFF->0, on each transition into FETCH from WB, MWB, MWR (on Mem_ready), BR or JMP; illegal instructions and HALT SHALL NOT count.
REQ-029 Latency with zero memory wait SHALL be: R/I 4 cycles, LW 5, SW 4, BEQ 3, JMP 3; each Mem_ready=0 cycle adds one.
REQ-030 Outputs SHALL be combinational from State and Opcode (plus Beq_alu in BR); State and Instr_count SHALL be registered.

Reset
REQ-031 When rst=1 at a rising edge, the next state SHALL be FETCH and Instr_count SHALL be 0, regardless of the current state, including HALT and memory-wait states.
REQ-032 While in FETCH after reset, outputs SHALL be Mem_read=1 and IorD=0, with all other strobes, Illegal and Halted equal to 0.
REQ-033 Reset SHALL abort any in-progress instruction with no further strobes and no count increment.

Verification
REQ-034 R-type add (Opcode 000010), Mem_ready=1 -> State 0,1,2,3,0; EXEC ALU_selection=0010, ALUsrcB=0; WB Reg_write=1, RegDst=1; Instr_count=1.
REQ-035 LW (100000), Mem_ready low 2 cycles in MRD -> MRD held 3 cycles, then MWB with MemtoReg=1; total 7 cycles; count +1.
REQ-036 BEQ (100010), Beq_alu=1 then a second BEQ with Beq_alu=0 -> BR PC_write=1, PC_source=01 for the first, PC_write=0 for the second; both counted.
REQ-037 Opcode 001000 (illegal code) -> DECODE->FETCH, Illegal pulse 1 cycle, count unchanged.
REQ-038 HALT (111111) for 10 cycles, then rst=1 -> Halted=1 held, State=10; one cycle after rst: State=0, Instr_count=0.
REQ-039 rst asserted during MWR with Mem_ready=0 -> next cycle State=0, Mem_write=0, count=0.
